// File: rtl/host_stream_bridge.sv
// Host pipe bridge: unpacks 16-bit pipe-in words into instruction/input beats
// and serializes emulator output beats back into 16-bit pipe-out words.
module host_stream_bridge #(
    parameter int WORD_W     = 16,
    parameter int INSN_WORDS = 3,
    parameter int IO_WORDS   = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WORD_W-1:0]            in_bits,
    output logic                         insns_valid,
    input  logic                         insns_ready,
    output logic [INSN_WORDS*WORD_W-1:0] insns_bits,
    output logic                         io_i_valid,
    input  logic                         io_i_ready,
    output logic [IO_WORDS*WORD_W-1:0]   io_i_bits,
    input  logic                         io_o_valid,
    output logic                         io_o_ready,
    input  logic [IO_WORDS*WORD_W-1:0]   io_o_bits,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WORD_W-1:0]            out_bits
);

    localparam int IDX_W = $clog2(IO_WORDS);
    localparam int CNT_W = WORD_W - 1;
    localparam logic [IDX_W-1:0] INSN_LAST = IDX_W'(INSN_WORDS - 1);
    localparam logic [IDX_W-1:0] IO_LAST   = IDX_W'(IO_WORDS - 1);

    typedef logic [IO_WORDS-1:0][WORD_W-1:0] beat_t;
    typedef enum logic [1:0] {FWD_HDR, FWD_LOAD, FWD_SEND} fwd_state_t;
    typedef enum logic {RET_IDLE, RET_DRAIN} ret_state_t;

    // Readies stay low during reset and rise on the first edge after release.
    logic                         active_q;
    fwd_state_t                   fwd_state_q, fwd_state_d;
    logic                         fwd_target_q, fwd_target_d;
    logic [CNT_W-1:0]             fwd_count_q, fwd_count_d;
    logic [IDX_W-1:0]             fwd_idx_q, fwd_idx_d;
    beat_t                        stage_q, beat;
    logic [INSN_WORDS*WORD_W-1:0] insns_bits_q;
    beat_t                        io_i_bits_q;
    ret_state_t                   ret_state_q, ret_state_d;
    logic [IDX_W-1:0]             ret_idx_q, ret_idx_d;
    beat_t                        cap_q;

    logic             in_fire, send_ready, send_fire, load_done, io_o_fire, out_fire;
    logic [IDX_W-1:0] last_idx;

    assign in_ready   = active_q && (fwd_state_q != FWD_SEND);
    assign in_fire    = in_valid && in_ready;
    assign last_idx   = fwd_target_q ? IO_LAST : INSN_LAST;
    assign send_ready = fwd_target_q ? io_i_ready : insns_ready;
    assign send_fire  = (fwd_state_q == FWD_SEND) && send_ready;
    assign load_done  = (fwd_state_q == FWD_LOAD) && in_fire && (fwd_idx_q == last_idx);

    assign insns_valid = (fwd_state_q == FWD_SEND) && !fwd_target_q;
    assign io_i_valid  = (fwd_state_q == FWD_SEND) && fwd_target_q;
    assign insns_bits  = insns_bits_q;
    assign io_i_bits   = io_i_bits_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        fwd_state_d  = fwd_state_q;
        fwd_target_d = fwd_target_q;
        fwd_count_d  = fwd_count_q;
        fwd_idx_d    = fwd_idx_q;
        case (fwd_state_q)
            FWD_HDR: if (in_fire) begin
                fwd_target_d = in_bits[WORD_W-1];
                fwd_count_d  = in_bits[CNT_W-1:0];
                fwd_idx_d    = '0;
                if (in_bits[CNT_W-1:0] != '0) fwd_state_d = FWD_LOAD;
            end
            FWD_LOAD: if (in_fire) begin
                if (fwd_idx_q == last_idx) fwd_state_d = FWD_SEND;
                else                       fwd_idx_d   = fwd_idx_q + 1'b1;
            end
            FWD_SEND: if (send_fire) begin
                fwd_idx_d = '0;
                if (fwd_count_q != '0) fwd_count_d = fwd_count_q - 1'b1;
                fwd_state_d = (fwd_count_q > CNT_W'(1)) ? FWD_LOAD : FWD_HDR;
            end
            default: fwd_state_d = FWD_HDR;
        endcase
    end

    // The word arriving in this cycle completes the beat alongside the staged ones.
    always_comb begin
        beat            = stage_q;
        beat[fwd_idx_q] = in_bits;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_q     <= 1'b0;
            fwd_state_q  <= FWD_HDR;
            fwd_target_q <= 1'b0;
            fwd_count_q  <= '0;
            fwd_idx_q    <= '0;
            insns_bits_q <= '0;
            io_i_bits_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            active_q     <= 1'b1;
            fwd_state_q  <= fwd_state_d;
            fwd_target_q <= fwd_target_d;
            fwd_count_q  <= fwd_count_d;
            fwd_idx_q    <= fwd_idx_d;
            if (load_done) begin
                if (fwd_target_q) io_i_bits_q  <= beat;
                else              insns_bits_q <= beat[INSN_WORDS-1:0];
            end
        end
    end

    // NOTE: pure data storage, always written before it is read, so no reset.
    always_ff @(posedge clock) begin
        if ((fwd_state_q == FWD_LOAD) && in_fire) stage_q[fwd_idx_q] <= in_bits;
        if (io_o_fire) cap_q <= io_o_bits;
    end

    assign io_o_ready = active_q && (ret_state_q == RET_IDLE);
    assign io_o_fire  = io_o_valid && io_o_ready;
    assign out_valid  = (ret_state_q == RET_DRAIN);
    assign out_fire   = out_valid && out_ready;
    assign out_bits   = out_valid ? cap_q[ret_idx_q] : '0;

    always_comb begin
        ret_state_d = ret_state_q;
        ret_idx_d   = ret_idx_q;
        case (ret_state_q)
            RET_IDLE: if (io_o_fire) begin
                ret_state_d = RET_DRAIN;
                ret_idx_d   = '0;
            end
            RET_DRAIN: if (out_fire) begin
                if (ret_idx_q == IO_LAST) ret_state_d = RET_IDLE;
                else                      ret_idx_d   = ret_idx_q + 1'b1;
            end
            default: ret_state_d = RET_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ret_state_q <= RET_IDLE;
            ret_idx_q   <= '0;
        end else begin
            ret_state_q <= ret_state_d;
            ret_idx_q   <= ret_idx_d;
        end
    end

endmodule

// File: doc/host_stream_bridge.md
Name: host_stream_bridge

Overview:
- Host-side end of the emulator top's host interface. Drives the emulator's instruction and input ports, and drains its output port.
- Forward path: unpacks a 16-bit host pipe-in word stream (header plus payload words) into multi-word beats on either the instruction interface or the input interface.
- Return path: serializes each multi-word output beat from the emulator into a 16-bit host pipe-out word stream.
- Sits between the Opal Kelly pipe FIFOs and the emulator top.

Parameters:
- WORD_W, 16, width of one host word and of each bundle element.
- INSN_WORDS, 3, words per instruction beat.
- IO_WORDS, 4, words per input beat and per output beat.

Ports:
- clock  in  1  sole clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  1  pipe-in word valid.
- in_ready  out  1  pipe-in word accepted.
- in_bits  in  WORD_W  pipe-in word.
- insns_valid  out  1  instruction beat valid.
- insns_ready  in  1  emulator accepts the instruction beat.
- insns_bits  out  INSN_WORDS*WORD_W  instruction beat; word k at bits [k*WORD_W +: WORD_W].
- io_i_valid  out  1  input beat valid.
- io_i_ready  in  1  emulator accepts the input beat.
- io_i_bits  out  IO_WORDS*WORD_W  input beat, same packing as insns_bits.
- io_o_valid  in  1  emulator output beat valid.
- io_o_ready  out  1  bridge accepts the output beat.
- io_o_bits  in  IO_WORDS*WORD_W  output beat, same packing.
- out_valid  out  1  pipe-out word valid.
- out_ready  in  1  host accepts the pipe-out word.
- out_bits  out  WORD_W  pipe-out word.

Behaviour:
- Reset values: in_ready=0, insns_valid=0, io_i_valid=0, all bits outputs=0, io_o_ready=0, out_valid=0, out_bits=0. Forward FSM enters HDR; return FSM enters IDLE.
- Reset asserted mid-operation discards partial beats, remaining beat counts and partially drained words. Nothing is replayed after reset.
- Header word format:
  - bit15 is the target: 0 = insns, 1 = io_i.
  - bits[14:0] is the beat count N.
  - The payload that follows is N*W words, where W = INSN_WORDS or IO_WORDS. Word 0 of each beat arrives first.
- Forward FSM, state HDR:
  - in_ready=1.
  - On handshake, latch target and N.
  - N=0: stay in HDR; the next word is a new header.
  - N>0: go to LOAD with word index 0.
- Forward FSM, state LOAD:
  - in_ready=1.
  - Each handshake writes in_bits into word slot [index] of the staging register and increments index.
  - The handshake that fills slot W-1 goes to SEND.
- Forward FSM, state SEND:
  - in_ready=0.
  - The target's valid is asserted, registered, in the cycle after the last word is accepted. Only that target's valid is ever asserted.
  - Bits and valid are held stable until ready.
  - On handshake, decrement N. N becomes 0: go to HDR. Otherwise go to LOAD with index 0.
  - A ready that arrives in the same cycle valid rises completes the handshake in that cycle.
- Non-target bits outputs keep their previous values and are don't-care while their valid is low.
- Minimum forward cost: one cycle per word plus one SEND cycle per beat.
- Return FSM, state IDLE:
  - io_o_ready=1, out_valid=0.
  - On io_o handshake, capture io_o_bits and go to DRAIN with index 0.
- Return FSM, state DRAIN:
  - io_o_ready=0, out_valid=1, out_bits = captured word [index].
  - On out handshake, increment index. After word IO_WORDS-1 is accepted, return to IDLE; the next capture can occur in the following cycle.
- The forward and return FSMs are fully independent. Simultaneous activity on both paths never stalls either one.
- The beat counter is 15 bits and never wraps: N is only decremented while nonzero.

Test Plan:
- Two-beat instruction load:
  - Stimulus: pipe-in 0x0002, BEAF, CAFE, DEAD, ABEF, DEAF, DADA with insns_ready=1.
  - Required: insns beat 1 = {DEAD,CAFE,BEAF} (word2..0), then beat 2 = {DADA,DEAF,ABEF}, each valid for exactly 1 cycle. FSM returns to HDR; io_i_valid never rises.
- Backpressure:
  - Stimulus: same stream with insns_ready held 0 for 5 cycles after valid rises.
  - Required: insns_valid and the bits stay stable for those 5 cycles, and in_ready=0 throughout. The handshake then fires once.
- Input beat plus zero-count header:
  - Stimulus: pipe-in 0x8000, then 0x8001, BADD, CAFE, BEAF, DEAD.
  - Required: the first header produces no beat. Exactly one io_i beat {DEAD,BEAF,CAFE,BADD} follows, and insns_valid stays 0.
- Output serialization:
  - Stimulus: io_o beat {FEAD,ABEE,BADD,DADD}, with out_ready toggling 1,0,1,1,0,1.
  - Required: out words DADD, BADD, ABEE, FEAD in order, each exactly once. io_o_ready=0 until FEAD is accepted.
- Concurrency:
  - Stimulus: an io_o beat arrives while the forward path is in LOAD.
  - Required: both paths complete with no lost or duplicated words.
- Reset mid-operation:
  - Stimulus: assert reset (0) after header 0x0001 plus 2 words, asynchronously between edges.
  - Required: all valids and readies drop immediately and outputs go to their reset values. After release, the next word (0x0001) is parsed as a header.
